// File: rtl/evm_crypt_sched.sv
// evm_crypt_sched: round-robin scheduler that shares one combinational
// encrypter among NUM_UNITS ballot units. It registers the selected record
// and the key pair onto the encrypter, waits SETTLE_CYCLES, captures the
// result and offers it on a valid/ready output.
// Optional macro EVM_DOUBLE_SAMPLE_EN adds a SAMPLE state that captures the
// encrypter output a second time and raises out_err on any difference.
module evm_crypt_sched #(
    parameter int NUM_UNITS     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_UNITS-1:0]    req,
    input  logic [NUM_UNITS*80-1:0] rec_in,
    output logic [NUM_UNITS-1:0]    grant,
    input  logic                    key_load,
    input  logic [63:0]             master_key_in,
    input  logic [63:0]             baby_key_in,
    output logic [79:0]             enc_data_in,
    output logic [63:0]             enc_master_key,
    output logic [63:0]             enc_baby_key,
    input  logic [79:0]             enc_data_out,
    input  logic [7:0]              enc_crc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [79:0]             out_data,
    output logic [7:0]              out_crc,
    output logic [2:0]              out_src,
    output logic                    out_err,
    output logic                    busy,
    output logic [15:0]             rec_count
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     wait_cnt;
    logic [2:0]           rr_ptr;
    logic [63:0]          master_key;
    logic [63:0]          baby_key;

    logic [7:0]           req_ext;
    logic [3:0]           cand;
    logic                 sel_found;
    logic [2:0]           sel_idx;
    logic [79:0]          sel_rec;
    logic [NUM_UNITS-1:0] sel_onehot;
    logic                 arb_fire;
    logic                 capture;
    logic                 handshake;

    assign enc_master_key = master_key;
    assign enc_baby_key   = baby_key;

    assign arb_fire  = (state == IDLE) && sel_found;
    assign capture   = (state == WAIT) && (wait_cnt == '0);
    assign handshake = (state == HOLD) && out_ready;

    // Find the first requesting unit at or after rr_ptr, wrapping around
    always_comb begin
        req_ext = '0;
        req_ext[NUM_UNITS-1:0] = req;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NUM_UNITS)) begin
                cand = cand - 4'(NUM_UNITS);
            end
            if (!sel_found && req_ext[cand[2:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[2:0];
            end
        end
    end

    // Select the winning record and build its one-hot grant
    always_comb begin
        sel_rec    = '0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (sel_idx == 3'(k)) begin
                sel_rec       = rec_in[k*80 +: 80];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
`ifdef EVM_DOUBLE_SAMPLE_EN
                    state_next = SAMPLE;
`else
                    state_next = HOLD;
`endif
                end
            end
            SAMPLE: begin
                state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Arbitration, key registers, settle counter, result capture and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            enc_data_in <= '0;
            out_src     <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            master_key  <= '0;
            baby_key    <= '0;
            out_data    <= '0;
            out_crc     <= '0;
            rec_count   <= '0;
        end else begin
            grant <= '0;
            if (state == IDLE && key_load) begin
                master_key <= master_key_in;
                baby_key   <= baby_key_in;
            end
            if (arb_fire) begin
                enc_data_in <= sel_rec;
                out_src     <= sel_idx;
                grant       <= sel_onehot;
                rr_ptr      <= (sel_idx == 3'(NUM_UNITS - 1)) ? 3'd0 : sel_idx + 3'd1;
                wait_cnt    <= CNT_W'(SETTLE_CYCLES);
            end
            if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (capture) begin
                out_data <= enc_data_out;
                out_crc  <= enc_crc;
            end
            if (handshake && rec_count != 16'hFFFF) begin
                rec_count <= rec_count + 16'd1;
            end
        end
    end

`ifdef EVM_DOUBLE_SAMPLE_EN
    logic err_q;

    // Second sample: flag any disagreement with the first capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (arb_fire) begin
            err_q <= 1'b0;
        end else if (state == SAMPLE) begin
            err_q <= (enc_data_out != out_data) || (enc_crc != out_crc);
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_evm_crypt_sched.sv
// Testbench for evm_crypt_sched: a stand-in encrypter, a transaction-level
// reference model, directed scenarios with literal expectations and a
// randomized phase compared against the model every cycle.
module tb_evm_crypt_sched;

    localparam int N = 4;
    localparam int S = 2;
`ifdef EVM_DOUBLE_SAMPLE_EN
    localparam int VLAT = S + 2;
`else
    localparam int VLAT = S + 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*80-1:0] rec_in;
    logic [N-1:0]   grant;
    logic           key_load;
    logic [63:0]    master_key_in;
    logic [63:0]    baby_key_in;
    logic [79:0]    enc_data_in;
    logic [63:0]    enc_master_key;
    logic [63:0]    enc_baby_key;
    logic [79:0]    enc_data_out;
    logic [7:0]     enc_crc;
    logic           out_valid;
    logic           out_ready;
    logic [79:0]    out_data;
    logic [7:0]     out_crc;
    logic [2:0]     out_src;
    logic           out_err;
    logic           busy;
    logic [15:0]    rec_count;

    logic           crc_flip;
    logic           perturb_en;
    logic [87:0]    stub;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic        m_inflight;
    int          m_age;
    int          m_src;
    int          m_ptr;
    logic [79:0] m_enc_in;
    logic [63:0] m_mk;
    logic [63:0] m_bk;
    logic [15:0] m_count;
    logic [79:0] m_out_data;
    logic [7:0]  m_out_crc;
    logic        m_err;

    evm_crypt_sched #(.NUM_UNITS(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rec_in(rec_in), .grant(grant),
        .key_load(key_load), .master_key_in(master_key_in), .baby_key_in(baby_key_in),
        .enc_data_in(enc_data_in), .enc_master_key(enc_master_key), .enc_baby_key(enc_baby_key),
        .enc_data_out(enc_data_out), .enc_crc(enc_crc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_crc(out_crc), .out_src(out_src), .out_err(out_err),
        .busy(busy), .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    // Stand-in encrypter: key-mix XOR and a byte-fold CRC
    function automatic logic [87:0] golden(input logic [79:0] d, input logic [63:0] mk,
                                           input logic [63:0] bk);
        logic [63:0] kmix;
        logic [79:0] o;
        logic [7:0]  c;
        kmix = mk ^ {bk[31:0], bk[63:32]};
        o = {d[79:64] ^ mk[63:48], d[63:0] ^ kmix};
        c = bk[7:0];
        for (int b = 0; b < 10; b++) c = c ^ o[b*8 +: 8];
        return {o, c};
    endfunction

    assign stub         = golden(enc_data_in, enc_master_key, enc_baby_key);
    assign enc_data_out = stub[87:8];
    assign enc_crc      = stub[7:0] ^ (crc_flip ? 8'h5A : 8'h00);

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 1'b0;
        m_age = 0;
        m_src = 0;
        m_ptr = 0;
        m_enc_in = '0;
        m_mk = '0;
        m_bk = '0;
        m_count = '0;
        m_out_data = '0;
        m_out_crc = '0;
        m_err = 1'b0;
        crc_flip = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit found;
        if (!m_inflight) begin
            if (key_load) begin
                m_mk = master_key_in;
                m_bk = baby_key_in;
            end
            found = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && req[idx]) begin
                    found = 1;
                    m_inflight = 1'b1;
                    m_age = 0;
                    m_src = idx;
                    m_enc_in = rec_in[idx*80 +: 80];
                    m_ptr = (idx + 1) % N;
                    m_err = 1'b0;
                end
            end
        end else if (m_age >= VLAT) begin
            if (out_ready) begin
                m_inflight = 1'b0;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
        end else begin
            m_age++;
            if (m_age == S + 1) {m_out_data, m_out_crc} = golden(m_enc_in, m_mk, m_bk);
`ifdef EVM_DOUBLE_SAMPLE_EN
            if (m_age == S + 2) m_err = crc_flip;
`endif
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] eg;
        logic         ev;
        eg = '0;
        if (m_inflight && m_age == 0) eg[m_src] = 1'b1;
        ev = m_inflight && (m_age >= VLAT);
        check("grant", 80'(grant), 80'(eg));
        check("busy", 80'(busy), 80'(m_inflight));
        check("out_valid", 80'(out_valid), 80'(ev));
        check("enc_data_in", enc_data_in, m_enc_in);
        check("enc_master_key", 80'(enc_master_key), 80'(m_mk));
        check("enc_baby_key", 80'(enc_baby_key), 80'(m_bk));
        check("rec_count", 80'(rec_count), 80'(m_count));
        if (ev) begin
            check("out_data", out_data, m_out_data);
            check("out_crc", 80'(out_crc), 80'(m_out_crc));
            check("out_src", 80'(out_src), 80'(m_src));
            check("out_err", 80'(out_err), 80'(m_err));
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput();
`ifdef EVM_DOUBLE_SAMPLE_EN
        crc_flip = perturb_en && m_inflight && (m_age == S + 1);
`else
        crc_flip = 1'b0;
`endif
    endtask

    // Random inputs; a unit only drops or replaces its request after its grant
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
                if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    rec_in[i*80 +: 80] = 80'({$urandom, $urandom, $urandom});
                end
            end else if (m_inflight && m_age == 0 && m_src == i) begin
                if ($urandom_range(1) == 0) begin
                    req[i] = 1'b0;
                end else begin
                    rec_in[i*80 +: 80] = 80'({$urandom, $urandom, $urandom});
                end
            end
        end
        key_load = ($urandom_range(7) == 0);
        master_key_in = {$urandom, $urandom};
        baby_key_in = {$urandom, $urandom};
        out_ready = 1'($urandom_range(1));
        perturb_en = 1'($urandom_range(1));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req = '0;
        key_load = 1'b0;
        out_ready = 1'b0;
        perturb_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
    endtask

    initial begin
        int got[5];
        int exp_order[5];
        int ng;
        exp_order = '{0, 1, 2, 3, 0};
        rec_in = '0;
        master_key_in = '0;
        baby_key_in = '0;
        doReset();

        // Single record with keys loaded alongside the request
        $display("[TB] single record with golden result");
        key_load = 1'b1;
        master_key_in = 64'h7854123695478523;
        baby_key_in = 64'h7541689775231405;
        req = 4'b0001;
        rec_in[79:0] = 80'd4568924;
        cycle();
        check("plan grant", 80'(grant), 80'(4'b0001));
        check("plan key", 80'(enc_master_key), 80'(64'h7854123695478523));
        req = '0;
        key_load = 1'b0;
        for (int c = 1; c < VLAT; c++) begin
            cycle();
            check("plan valid early", 80'(out_valid), 80'(1'b0));
        end
        cycle();
        check("plan valid", 80'(out_valid), 80'(1'b1));
        check("plan data", out_data, 80'h7854_0D770633_E0435AE8);
        check("plan crc", 80'(out_crc), 80'(8'h77));
        check("plan src", 80'(out_src), 80'(3'd0));

        // Stall in HOLD with a pending request and a key load attempt
        req = 4'b0010;
        rec_in[159:80] = 80'h1234_5678_9ABC_DEF0_1357;
        key_load = 1'b1;
        master_key_in = 64'hDEAD_BEEF_0000_1111;
        baby_key_in = 64'h2222_3333_4444_5555;
        repeat (10) cycle();
        check("stall valid", 80'(out_valid), 80'(1'b1));
        check("stall grant", 80'(grant), 80'(4'b0000));
        check("stall count", 80'(rec_count), 80'(16'd0));
        check("stall key", 80'(enc_baby_key), 80'(64'h7541689775231405));
        check("stall data", out_data, 80'h7854_0D770633_E0435AE8);
        key_load = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("plan count", 80'(rec_count), 80'(16'd1));
        cycle();
        check("next grant", 80'(grant), 80'(4'b0010));
        req = '0;
        repeat (VLAT + 2) cycle();

        // Continuous requests from all units
        $display("[TB] round-robin with all units requesting");
        doReset();
        for (int i = 0; i < N; i++) rec_in[i*80 +: 80] = 80'({$urandom, $urandom, $urandom});
        req = 4'b1111;
        out_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            cycle();
            for (int k = 0; k < N; k++) begin
                if (grant[k]) begin
                    got[ng] = k;
                    ng++;
                end
            end
        end
        req = '0;
        check("rr grants seen", 80'(ng), 80'(5));
        for (int i = 0; i < 5; i++) check($sformatf("rr order %0d", i), 80'(got[i]), 80'(exp_order[i]));
        repeat (VLAT + 2) cycle();
        check("rr count", 80'(rec_count), 80'(16'd5));

        // Asynchronous reset during WAIT, then arbitration restarts from unit 0
        $display("[TB] reset during WAIT");
        doReset();
        rec_in[239:160] = 80'hA5A5_5A5A_0F0F_F0F0_1111;
        req = 4'b0100;
        cycle();
        req = '0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", 80'(busy), 80'(1'b0));
        check("arst enc_data_in", enc_data_in, 80'd0);
        check("arst out_src", 80'(out_src), 80'(3'd0));
        check("arst grant", 80'(grant), 80'(4'b0000));
        model_reset();
        @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
        req = 4'b1100;
        cycle();
        check("post-reset grant", 80'(grant), 80'(4'b0100));
        req = '0;
        out_ready = 1'b1;
        repeat (VLAT + 2) cycle();

`ifdef EVM_DOUBLE_SAMPLE_EN
        // Encrypter CRC disturbed between the two samples
        $display("[TB] double-sample disagreement");
        out_ready = 1'b0;
        perturb_en = 1'b1;
        req = 4'b0001;
        cycle();
        req = '0;
        repeat (VLAT) cycle();
        check("dbl err set", 80'(out_err), 80'(1'b1));
        perturb_en = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        req = 4'b0001;
        cycle();
        check("dbl err cleared", 80'(out_err), 80'(1'b0));
        req = '0;
        out_ready = 1'b1;
        repeat (VLAT + 2) cycle();
`endif

        // Randomized traffic against the model
        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
